// File: rtl/pipe_pkg.sv
// Shared pipeline constants, load-size encoding and the MEM/WB payload type.
// The retire-counter option is controlled by the WB_RETIRE_CNT_EN macro.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        LOAD_BYTE = 2'b00,
        LOAD_HALF = 2'b01,
        LOAD_WORD = 2'b10,
        LOAD_RSVD = 2'b11
    } load_size_e;

    // Contents of the WB stage register.
    typedef struct packed {
        logic              wb_valid;
        logic              reg_write;
        logic [REG_AW-1:0] write_register;
        logic [DATA_W-1:0] write_data;
    } wb_result_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side inputs and WB-side outputs of the MEM/WB stage.
// master = MEM stage / environment, slave = the MEM/WB register.
interface mem_wb_stage_if;
    import pipe_pkg::*;

    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              in_RegWrite;
    logic              in_MemtoReg;
    logic [1:0]        in_load_size;
    logic              in_load_unsigned;
    logic [DATA_W-1:0] in_ALUResult;
    logic [DATA_W-1:0] in_MemData;
    logic [REG_AW-1:0] in_WriteRegister;

    logic              wb_valid;
    logic              RegWrite;
    logic [REG_AW-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;

    modport master (
        output stall, flush, in_valid, in_RegWrite, in_MemtoReg, in_load_size,
               in_load_unsigned, in_ALUResult, in_MemData, in_WriteRegister,
        input  wb_valid, RegWrite, WriteRegister, WriteData
    );

    modport slave (
        input  stall, flush, in_valid, in_RegWrite, in_MemtoReg, in_load_size,
               in_load_unsigned, in_ALUResult, in_MemData, in_WriteRegister,
        output wb_valid, RegWrite, WriteRegister, WriteData
    );

endinterface

// File: rtl/load_extend.sv
// Combinational little-endian lane select and sign/zero extension of load data.
module load_extend
    import pipe_pkg::*;
(
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] ext_data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane; halfwords ignore off[0] (aligned down).
    always_comb begin
        byte_lane = mem_data[7:0];
        case (off)
            2'd1:    byte_lane = mem_data[15:8];
            2'd2:    byte_lane = mem_data[23:16];
            2'd3:    byte_lane = mem_data[31:24];
            default: byte_lane = mem_data[7:0];
        endcase
        half_lane = off[1] ? mem_data[31:16] : mem_data[15:0];
    end

    // Extend the lane to the datapath width; word and reserved pass through.
    always_comb begin
        ext_data_c = mem_data;
        case (load_size_e'(size))
            LOAD_BYTE: ext_data_c = is_unsigned ? {24'h0, byte_lane}
                                                : {{24{byte_lane[7]}}, byte_lane};
            LOAD_HALF: ext_data_c = is_unsigned ? {16'h0, half_lane}
                                                : {{16{half_lane[15]}}, half_lane};
            default:   ext_data_c = mem_data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback formatting.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mem_wb_stage_if.slave     mw
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [DATA_W-1:0] retired_count
`endif
);

    logic [DATA_W-1:0] load_val_c;
    logic [DATA_W-1:0] fmt_data_c;
    wb_result_t        wb_d;
    wb_result_t        wb_q;

    load_extend u_load_extend (
        .mem_data    (mw.in_MemData),
        .off         (mw.in_ALUResult[1:0]),
        .size        (mw.in_load_size),
        .is_unsigned (mw.in_load_unsigned),
        .ext_data_c  (load_val_c)
    );

    assign fmt_data_c = mw.in_MemtoReg ? load_val_c : mw.in_ALUResult;

    // Next WB contents: flush clears, stall holds, otherwise capture.
    always_comb begin
        wb_d = wb_q;
        if (mw.flush) begin
            wb_d = '0;
        end else if (!mw.stall) begin
            wb_d.wb_valid       = mw.in_valid;
            wb_d.reg_write      = mw.in_valid & mw.in_RegWrite;
            wb_d.write_register = mw.in_WriteRegister;
            wb_d.write_data     = fmt_data_c;
        end
    end

    // WB stage register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign mw.wb_valid      = wb_q.wb_valid;
    assign mw.RegWrite      = wb_q.reg_write;
    assign mw.WriteRegister = wb_q.write_register;
    assign mw.WriteData     = wb_q.write_data;

`ifdef WB_RETIRE_CNT_EN
    logic [DATA_W-1:0] retired_count_d;
    logic [DATA_W-1:0] retired_count_q;

    // Count valid instructions on capture edges only; wraps naturally.
    always_comb begin
        retired_count_d = retired_count_q;
        if (!mw.flush && !mw.stall && mw.in_valid) begin
            retired_count_d = retired_count_q + DATA_W'(1);
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized plus directed bench for mem_wb_stage against a behavioural model.
module tb_mem_wb_stage;

    logic clk;
    logic rst_n;

    mem_wb_stage_if mw ();

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_count;
`endif

    mem_wb_stage dut (
        .clk           (clk),
        .reset         (rst_n),
        .mw            (mw.slave)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Expected WB state.
    logic        m_valid;
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic [31:0] m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Writeback value from the architectural load rules.
    function automatic logic [31:0] ref_format(input logic m2r, input logic [1:0] size,
                                               input logic uns, input logic [31:0] alu,
                                               input logic [31:0] mem);
        logic [31:0] v;
        int          off;
        if (!m2r) return alu;
        off = int'(alu[1:0]);
        if (size == 2'b00) begin
            v = (mem >> (8 * off)) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (mem >> ((off / 2) * 16)) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_rw = 1'b0; m_wreg = '0; m_wdata = '0; m_cnt = '0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        if (mw.flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
        end else if (!mw.stall) begin
            m_valid = mw.in_valid;
            m_rw    = mw.in_valid && mw.in_RegWrite;
            m_wreg  = mw.in_WriteRegister;
            m_wdata = ref_format(mw.in_MemtoReg, mw.in_load_size, mw.in_load_unsigned,
                                 mw.in_ALUResult, mw.in_MemData);
            if (mw.in_valid) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".wb_valid"}, 32'(mw.wb_valid), 32'(m_valid));
        check_val({tag, ".RegWrite"}, 32'(mw.RegWrite), 32'(m_rw));
        check_val({tag, ".WriteRegister"}, 32'(mw.WriteRegister), 32'(m_wreg));
        check_val({tag, ".WriteData"}, mw.WriteData, m_wdata);
`ifdef WB_RETIRE_CNT_EN
        check_val({tag, ".retired_count"}, retired_count, m_cnt);
`endif
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [1:0] size,
                         input logic uns, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] wreg);
        mw.in_valid = v; mw.in_RegWrite = rw; mw.in_MemtoReg = m2r;
        mw.in_load_size = size; mw.in_load_unsigned = uns;
        mw.in_ALUResult = alu; mw.in_MemData = mem; mw.in_WriteRegister = wreg;
    endtask

    task automatic drive_random();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
              $urandom, $urandom, 5'($urandom));
    endtask

    task automatic load_case(input string tag, input logic [1:0] size, input logic uns,
                             input logic [31:0] alu, input logic [31:0] mem,
                             input logic [31:0] exp_const);
        drive(1'b1, 1'b1, 1'b1, size, uns, alu, mem, 5'd4);
        tick(tag);
        check_val({tag, ".const"}, mw.WriteData, exp_const);
    endtask

    logic [31:0] held_data;
    logic [4:0]  held_reg;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        mw.stall = 1'b0; mw.flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ALU writeback
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 5'd9);
        tick("alu");
        check_val("alu.const_data", mw.WriteData, 32'h1234_5678);
        check_val("alu.const_reg", 32'(mw.WriteRegister), 32'd9);
        check_val("alu.const_rw", 32'(mw.RegWrite), 32'd1);

        // Load formatting
        load_case("lb_off3_s", 2'b00, 1'b0, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80);
        load_case("lb_off3_u", 2'b00, 1'b1, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080);
        load_case("lb_off1_s", 2'b00, 1'b0, 32'h0000_1001, 32'h80FF_7F01, 32'h0000_007F);
        load_case("lh_off2_s", 2'b01, 1'b0, 32'h0000_2002, 32'h8001_ABCD, 32'hFFFF_8001);
        load_case("lh_off1_u", 2'b01, 1'b1, 32'h0000_2001, 32'h8001_ABCD, 32'h0000_ABCD);
        load_case("lw_off3",   2'b10, 1'b0, 32'h0000_2003, 32'h8001_ABCD, 32'h8001_ABCD);
        load_case("rsvd_off2", 2'b11, 1'b0, 32'h0000_2002, 32'h8001_ABCD, 32'h8001_ABCD);

        // Stall holds for three cycles while inputs change
        held_data = mw.WriteData;
        held_reg  = mw.WriteRegister;
        mw.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick("stall");
            check_val("stall.const_data", mw.WriteData, held_data);
            check_val("stall.const_reg", 32'(mw.WriteRegister), 32'(held_reg));
        end

        // Flush beats stall
        mw.flush = 1'b1;
        tick("stall_flush");
        check_val("flush.const_data", mw.WriteData, 32'h0);
        check_val("flush.const_valid", 32'(mw.wb_valid), 32'h0);
        mw.stall = 1'b0; mw.flush = 1'b0;

        // Invalid instruction never writes
        drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h5555_AAAA, 32'h0, 5'd7);
        tick("invalid");
        check_val("invalid.const_rw", 32'(mw.RegWrite), 32'd0);

        // Asynchronous reset mid-cycle, during a stall
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 5'd17);
        tick("pre_reset");
        mw.stall = 1'b1;
        @(posedge clk);
        #2;
        model_edge();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        check_val("async_reset.const_data", mw.WriteData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mw.stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0BAD_CAFE, 32'h0, 5'd3);
        tick("post_reset");
        check_val("post_reset.const_data", mw.WriteData, 32'h0BAD_CAFE);

`ifdef WB_RETIRE_CNT_EN
        // Counter: 5 valid captures, 2 stalls, 1 flush
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'(i), 32'h0, 5'd1);
            mw.stall = (i == 2 || i == 5);
            mw.flush = (i == 6);
            tick("cnt_seq");
        end
        mw.stall = 1'b0; mw.flush = 1'b0;
        check_val("cnt.const5", retired_count, 32'd5);

        // Wrap from all-ones
        @(negedge clk);
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        m_cnt = 32'hFFFF_FFFF;
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1, 32'h0, 5'd2);
        tick("cnt_wrap");
        check_val("cnt.const_wrap", retired_count, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive_random();
            mw.stall = ($urandom_range(0, 5) == 0);
            mw.flush = ($urandom_range(0, 9) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback formatter of the 5-stage MIPS pipeline.
- Captures memory-stage results and extracts and extends load data.
- Drives RegWrite, WriteRegister and WriteData to the register file and to the WB forwarding unit.
- All outputs are registered: one-cycle latency from the MEM stage.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold the current WB contents.
- flush  in  1  squash the incoming bubble and clear WB.
- in_valid  in  1  the MEM stage holds a real instruction.
- in_RegWrite  in  1  the instruction writes a GPR.
- in_MemtoReg  in  1  1 = write load data, 0 = write ALU result.
- in_load_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- in_load_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- in_ALUResult  in  32  ALU result; bits [1:0] also give the byte offset of a load.
- in_MemData  in  32  raw aligned word read from data memory.
- in_WriteRegister  in  5  destination register.
- wb_valid  out  1  the WB stage holds a real instruction.
- RegWrite  out  1  write enable to the regfile and forwarding unit.
- WriteRegister  out  5  destination register.
- WriteData  out  32  final writeback value.

Behaviour:
- Reset: asserting reset low clears all outputs to 0 immediately, independent of clk.
- Release is synchronous to the first rising edge after reset goes high.
- Priority at each rising edge: flush > stall > capture.
- flush=1:
  - wb_valid=0 and RegWrite=0.
  - WriteRegister and WriteData are cleared to 0.
- stall=1 and flush=0: every output holds its value.
- Capture:
  - wb_valid <= in_valid.
  - RegWrite <= in_valid & in_RegWrite.
  - WriteRegister <= in_WriteRegister.
  - WriteData <= formatted value.
- Formatting is combinational on the inputs and registered at capture.
  - in_MemtoReg=0: value = in_ALUResult.
  - in_MemtoReg=1: little-endian lane select, with off = in_ALUResult[1:0]:
    - byte: lane = in_MemData[8*off+7 : 8*off], extended to 32 bits.
    - halfword: uses off[1] only (off[0] ignored, aligned down); lane = in_MemData[16*off[1]+15 : 16*off[1]], extended.
    - word or reserved: in_MemData unchanged; off ignored.
  - Extension: sign-extend from the lane MSB unless in_load_unsigned=1, then zero-extend.
- RegWrite is not gated on WriteRegister==0; suppressing writes to $0 is the consumer's job.
- in_valid=0 with in_RegWrite=1 gives RegWrite=0.
- stall and flush in the same cycle: flush wins.
- reset during a stall clears the stage; the held instruction is lost.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retired_count, 32 bits.
  - Increments by 1 on each capture edge with in_valid=1 (not on stall or flush edges).
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared to 0 by reset.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - LOAD_BYTE=2'b00, LOAD_HALF=2'b01, LOAD_WORD=2'b10.
  - DATA_W and REG_AW.
- Sub-module load_extend: purely combinational (MemData, off, size, unsigned) -> 32-bit value.
  - Instantiated once; verified standalone.

Test Plan:
- Reset: reset=0 mid-cycle with outputs nonzero -> all outputs 0 before the next edge; the first edge after release captures normally.
- ALU writeback: in_valid=1, RegWrite=1, MemtoReg=0, ALUResult=0x12345678, WriteRegister=9 -> next edge: RegWrite=1, WriteRegister=9, WriteData=0x12345678.
- Byte loads, MemData=0x80FF7F01:
  - off=3 signed -> 0xFFFFFF80.
  - off=3 unsigned -> 0x00000080.
  - off=1 signed -> 0x0000007F.
- Halfword loads, MemData=0x8001ABCD:
  - off=2 signed -> 0xFFFF8001.
  - off=1 (aligned down) unsigned -> 0x0000ABCD.
  - word, off=3 -> 0x8001ABCD.
- Stall and flush:
  - stall=1 for 3 cycles while inputs change -> outputs frozen.
  - Then stall=1 with flush=1 -> wb_valid=0, RegWrite=0, WriteData=0.
- Invalid gating: in_valid=0, in_RegWrite=1 -> RegWrite=0.
  - With WB_RETIRE_CNT_EN: 5 valid captures, 2 stalls and 1 flush -> retired_count=5.
  - Count preset to 0xFFFFFFFF plus one valid capture -> retired_count=0.
